// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_queue
//  Description : In-order load/store queue for an out-of-order core. Entries
//                wait in a circular FIFO for their address/data operands
//                (captured from ALU and load-result broadcasts). The head is
//                issued to memory by a small IDLE/MEM/DRAIN FSM. Stores issue
//                only once the ROB has committed them. A flush keeps only the
//                committed stores, compacted in order behind the head.
//  Ports       : clockIn/resetIn (async active-low), readyIn (stall),
//                clearFlag (flush), add* (enqueue), full,
//                alu* (ALU broadcast), rob* (commit / ROB head tag),
//                out* (load result broadcast), mem* (memory request/response)
//  Config      : define LSQ_IO_GUARD_EN to hold loads at or above IO_BASE
//                until their tag reaches the ROB head.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_queue #(
  parameter int          ROB_WIDTH = 4,
  parameter int          LSQ_WIDTH = 4,
  parameter logic [31:0] IO_BASE   = 32'h00030000
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 clearFlag,
  input  logic                 addFlag,
  input  logic [3:0]           addOp,
  input  logic [31:0]          addVj,
  input  logic [31:0]          addVk,
  input  logic [ROB_WIDTH-1:0] addQj,
  input  logic [ROB_WIDTH-1:0] addQk,
  input  logic                 addQjBusy,
  input  logic                 addQkBusy,
  input  logic [31:0]          addImm,
  input  logic [ROB_WIDTH-1:0] addDest,
  output logic                 full,
  input  logic                 aluFlag,
  input  logic [31:0]          aluVal,
  input  logic [ROB_WIDTH-1:0] aluDest,
  input  logic                 robFlag,
  input  logic [ROB_WIDTH-1:0] robDest,
  input  logic [ROB_WIDTH-1:0] robHeadDest,
  output logic                 outFlag,
  output logic [31:0]          outVal,
  output logic [ROB_WIDTH-1:0] outDest,
  output logic                 memOutFlag,
  output logic [2:0]           memOp,
  output logic [31:0]          memAddr,
  output logic [31:0]          memDataOut,
  input  logic [31:0]          memDataIn,
  input  logic                 memOkFlag
);

  localparam int DEPTH = 2 ** LSQ_WIDTH;

  typedef logic [LSQ_WIDTH-1:0] ptr_t;
  typedef logic [LSQ_WIDTH:0]   cnt_t;

  typedef struct packed {
    logic [3:0]           op;
    logic [31:0]          vj;
    logic [31:0]          vk;
    logic [31:0]          imm;
    logic [ROB_WIDTH-1:0] qj;
    logic [ROB_WIDTH-1:0] qk;
    logic                 qj_busy;
    logic                 qk_busy;
    logic [ROB_WIDTH-1:0] dest;
    logic                 committed;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  ptr_t                 head_q, head_d;
  ptr_t                 tail_q, tail_d;
  cnt_t                 count_q, count_d;
  state_t               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic                 out_flag_q, out_flag_d;
  logic [31:0]          out_val_q, out_val_d;
  logic [ROB_WIDTH-1:0] out_dest_q, out_dest_d;
  entry_t               entry_q [DEPTH];
  entry_t               entry_d [DEPTH];
  entry_t               upd     [DEPTH];

  entry_t               head_e;
  entry_t               new_e;
  logic [31:0]          head_addr;
  logic                 head_issuable;
  logic                 is_full;
  logic                 pop;
  logic                 push;

  function automatic logic [31:0] load_ext(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op[1:0])
      2'b00:   r = op[2] ? {24'b0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   r = op[2] ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign head_e     = entry_q[head_q];
  assign head_addr  = head_e.vj + head_e.imm;
  assign is_full    = (count_q == cnt_t'(DEPTH));
  assign full       = is_full;
  // The request flag drops in the same cycle the response arrives so the
  // controller never sees a second request for the completed access.
  assign memOutFlag = mem_req_q & ~memOkFlag;
  assign memAddr    = head_addr;
  assign memOp      = {head_e.op[3], head_e.op[1:0]};
  assign memDataOut = head_e.vk;
  assign outFlag    = out_flag_q;
  assign outVal     = out_val_q;
  assign outDest    = out_dest_q;

  // Head readiness: loads need their base register, stores additionally
  // need their data operand and ROB commit.
  always_comb begin
    if (head_e.op[3]) begin
      head_issuable = head_e.committed & ~head_e.qj_busy & ~head_e.qk_busy;
    end else begin
      head_issuable = ~head_e.qj_busy;
`ifdef LSQ_IO_GUARD_EN
      if ((head_addr >= IO_BASE) && (robHeadDest != head_e.dest)) begin
        head_issuable = 1'b0;
      end
`endif
    end
  end

`ifdef LSQ_IO_GUARD_EN
`else
  logic unused_rob_head;
  assign unused_rob_head = ^robHeadDest;
`endif

  // New entry, with same-cycle broadcasts bypassed into its operands.
  always_comb begin
    new_e         = '0;
    new_e.op      = addOp;
    new_e.vj      = addVj;
    new_e.vk      = addVk;
    new_e.imm     = addImm;
    new_e.qj      = addQj;
    new_e.qk      = addQk;
    new_e.dest    = addDest;
    new_e.qj_busy = addQjBusy;
    new_e.qk_busy = addQkBusy;
    if (addQjBusy && aluFlag && (aluDest == addQj)) begin
      new_e.vj = aluVal;
      new_e.qj_busy = 1'b0;
    end else if (addQjBusy && out_flag_q && (out_dest_q == addQj)) begin
      new_e.vj = out_val_q;
      new_e.qj_busy = 1'b0;
    end
    if (addQkBusy && aluFlag && (aluDest == addQk)) begin
      new_e.vk = aluVal;
      new_e.qk_busy = 1'b0;
    end else if (addQkBusy && out_flag_q && (out_dest_q == addQk)) begin
      new_e.vk = out_val_q;
      new_e.qk_busy = 1'b0;
    end
  end

  // Operand wake-up and store commit applied to every stored entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      upd[i] = entry_q[i];
      if (entry_q[i].qj_busy && aluFlag && (entry_q[i].qj == aluDest)) begin
        upd[i].vj = aluVal;
        upd[i].qj_busy = 1'b0;
      end else if (entry_q[i].qj_busy && out_flag_q && (entry_q[i].qj == out_dest_q)) begin
        upd[i].vj = out_val_q;
        upd[i].qj_busy = 1'b0;
      end
      if (entry_q[i].qk_busy && aluFlag && (entry_q[i].qk == aluDest)) begin
        upd[i].vk = aluVal;
        upd[i].qk_busy = 1'b0;
      end else if (entry_q[i].qk_busy && out_flag_q && (entry_q[i].qk == out_dest_q)) begin
        upd[i].vk = out_val_q;
        upd[i].qk_busy = 1'b0;
      end
      if (robFlag && entry_q[i].op[3] && (entry_q[i].dest == robDest)) begin
        upd[i].committed = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_t wp;
    ptr_t base;
    ptr_t idx;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    out_flag_d = out_flag_q;
    out_val_d  = out_val_q;
    out_dest_d = out_dest_q;
    entry_d    = entry_q;
    pop        = 1'b0;
    push       = 1'b0;
    wp         = '0;
    base       = head_q;
    idx        = head_q;

    if (readyIn) begin
      out_flag_d = 1'b0;
      pop  = (state_q == MEM) && memOkFlag;
      push = addFlag && !clearFlag && !is_full;

      case (state_q)
        IDLE: begin
          // A flush may discard the head this cycle, so issue waits for it.
          if ((count_q != '0) && head_issuable && !clearFlag) begin
            state_d   = MEM;
            mem_req_d = 1'b1;
          end
        end
        MEM: begin
          if (memOkFlag) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            if (!head_e.op[3] && !clearFlag) begin
              out_flag_d = 1'b1;
              out_val_d  = load_ext(head_e.op, memDataIn);
              out_dest_d = head_e.dest;
            end
          end else if (clearFlag && !head_e.op[3]) begin
            // The flushed load is already in the memory controller; wait
            // for its response without presenting a new request.
            state_d   = DRAIN;
            mem_req_d = 1'b0;
          end
        end
        DRAIN: begin
          if (memOkFlag) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase

      if (clearFlag) begin
        // Keep committed stores only, packed in age order from the
        // (post-pop) head. A completing head entry is never kept.
        base = head_q + ptr_t'(pop);
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_q + ptr_t'(k);
          if ((cnt_t'(k) < count_q) && !(pop && (k == 0)) && upd[idx].committed) begin
            entry_d[base + wp[LSQ_WIDTH-1:0]] = upd[idx];
            wp = wp + cnt_t'(1);
          end
        end
        head_d  = base;
        tail_d  = base + wp[LSQ_WIDTH-1:0];
        count_d = wp;
      end else begin
        entry_d = upd;
        if (push) begin
          entry_d[tail_q] = new_e;
          tail_d = tail_q + ptr_t'(1);
        end
        head_d  = head_q + ptr_t'(pop);
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      out_flag_q <= 1'b0;
      out_val_q  <= '0;
      out_dest_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      out_flag_q <= out_flag_d;
      out_val_q  <= out_val_d;
      out_dest_q <= out_dest_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule
`default_nettype wire
